// File: rtl/ysyx_24100027_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_24100027_pkg
//  Description : Shared types and constants for the instruction fetch unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package ysyx_24100027_pkg;

  // Fetch-unit sequencing states; FAULT is absorbing until reset.
  typedef enum logic [2:0] {
    S_BOOT  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_DISP  = 3'd3,
    S_EXEC  = 3'd4,
    S_FAULT = 3'd5
  } state_t;

  // PC the core starts fetching from after reset.
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

  // Canonical RISC-V nop (addi x0, x0, 0), presented to decode out of reset.
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

endpackage : ysyx_24100027_pkg
`default_nettype wire

// File: rtl/ysyx_24100027_nextpc.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_24100027_nextpc
//  Description : Next-PC datapath: base/addend select, 32-bit add, jalr
//                bit-0 clear and word-misalignment flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module ysyx_24100027_nextpc (
  input  logic [31:0] i_pc,
  input  logic [31:0] i_rs1,
  input  logic [31:0] i_imm,
  input  logic        i_actr,
  input  logic        i_bctr,
  output logic [31:0] o_next_pc,
  output logic        o_misaligned
);

  logic [31:0] w_base;
  logic [31:0] w_addend;
  logic [31:0] w_sum;

  // Select operands, add modulo 2^32, clear bit 0 for jalr, flag misalignment.
  always_comb begin
    w_base       = i_bctr ? i_rs1 : i_pc;
    w_addend     = i_actr ? i_imm : 32'd4;
    w_sum        = w_base + w_addend;
    o_next_pc    = i_bctr ? {w_sum[31:1], 1'b0} : w_sum;
    o_misaligned = (o_next_pc[1:0] != 2'b00);
  end

endmodule : ysyx_24100027_nextpc
`default_nettype wire

// File: rtl/ysyx_24100027_ifu.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_24100027_ifu
//  Description : Instruction fetch unit. Holds the architectural PC, issues
//                one imem request at a time, hands the instruction to decode
//                and advances the PC on commit.
//  Revision    : 1.0 - initial release
// ============================================================================
module ysyx_24100027_ifu
  import ysyx_24100027_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        PCActr,
  input  logic        PCBctr,
  input  logic [31:0] imm,
  input  logic [31:0] rs1,
  input  logic        commit_valid,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [31:0] req_addr,
  input  logic        resp_valid,
  input  logic [31:0] resp_data,
  input  logic        resp_err,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        fault
);

  state_t      r_state;
  logic        r_boot_done;
  logic [31:0] r_pc;
  logic [31:0] r_inst;
  logic [31:0] r_inst_pc;
  logic        r_req_valid;
  logic        r_inst_valid;
  logic        r_fault;

  logic [31:0] w_next_pc;
  logic        w_misaligned;

  ysyx_24100027_nextpc u_nextpc (
    .i_pc         (r_pc),
    .i_rs1        (rs1),
    .i_imm        (imm),
    .i_actr       (PCActr),
    .i_bctr       (PCBctr),
    .o_next_pc    (w_next_pc),
    .o_misaligned (w_misaligned)
  );

  // Fetch sequencer; outputs are registered alongside the state so that
  // nothing downstream sees a combinational path from the inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_BOOT;
      r_boot_done  <= 1'b0;
      r_pc         <= RESET_PC;
      r_inst       <= NOP_INST;
      r_inst_pc    <= RESET_PC;
      r_req_valid  <= 1'b0;
      r_inst_valid <= 1'b0;
      r_fault      <= 1'b0;
    end else begin
      case (r_state)
        // The first edge after release only arms the boot flag, so the first
        // request appears on the second edge.
        S_BOOT: begin
          if (r_boot_done) begin
            r_state     <= S_REQ;
            r_req_valid <= 1'b1;
          end else begin
            r_boot_done <= 1'b1;
          end
        end
        S_REQ: begin
          if (req_ready) begin
            r_state     <= S_WAIT;
            r_req_valid <= 1'b0;
          end
        end
        S_WAIT: begin
          if (resp_valid) begin
            if (resp_err) begin
              r_state <= S_FAULT;
              r_fault <= 1'b1;
            end else begin
              r_inst       <= resp_data;
              r_inst_pc    <= r_pc;
              r_inst_valid <= 1'b1;
              r_state      <= S_DISP;
            end
          end
        end
        S_DISP: begin
          if (inst_ready) begin
            r_inst_valid <= 1'b0;
            r_state      <= S_EXEC;
          end
        end
        // A misaligned target leaves the PC at the faulting instruction.
        S_EXEC: begin
          if (commit_valid) begin
            if (w_misaligned) begin
              r_state <= S_FAULT;
              r_fault <= 1'b1;
            end else begin
              r_pc        <= w_next_pc;
              r_req_valid <= 1'b1;
              r_state     <= S_REQ;
            end
          end
        end
        S_FAULT: begin
          r_fault      <= 1'b1;
          r_req_valid  <= 1'b0;
          r_inst_valid <= 1'b0;
        end
        default: begin
          r_state      <= S_FAULT;
          r_fault      <= 1'b1;
          r_req_valid  <= 1'b0;
          r_inst_valid <= 1'b0;
        end
      endcase
    end
  end

  assign req_valid  = r_req_valid;
  assign req_addr   = r_pc;
  assign inst_valid = r_inst_valid;
  assign inst       = r_inst;
  assign inst_pc    = r_inst_pc;
  assign fault      = r_fault;

endmodule : ysyx_24100027_ifu
`default_nettype wire

// File: doc/ysyx_24100027_ifu.md
# ysyx_24100027_ifu

Instruction fetch unit. It holds the architectural PC, fetches one instruction at a time from instruction memory over a valid/ready request and response interface, and presents the instruction to decode. On each commit it computes the next PC from the branch controller's `PCActr`/`PCBctr` selects. It is the stage directly downstream of the branch controller.

## Interface
- `RESET_PC`, default 32'h8000_0000: PC loaded on reset.
- `clk`  in  1  clock, all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `PCActr`  in  1  addend select: 1 = `imm`, 0 = 4.
- `PCBctr`  in  1  base select: 1 = `rs1`, 0 = current PC.
- `imm`  in  32  immediate from decode.
- `rs1`  in  32  register operand.
- `commit_valid`  in  1  one-cycle pulse: current instruction done, selects valid.
- `req_valid`  out  1  fetch request.
- `req_ready`  in  1  imem accepts request.
- `req_addr`  out  32  fetch address.
- `resp_valid`  in  1  imem data valid.
- `resp_data`  in  32  instruction word.
- `resp_err`  in  1  bus error, qualified by `resp_valid`.
- `inst_valid`  out  1  instruction available to decode.
- `inst_ready`  in  1  decode accepts instruction.
- `inst`  out  32  instruction word.
- `inst_pc`  out  32  PC of `inst`.
- `fault`  out  1  sticky fetch fault.

## Operation
- States: BOOT → REQ → WAIT → DISP → EXEC → REQ; FAULT is absorbing.
- **BOOT:** one cycle after reset release, then go to REQ.
- **REQ:** `req_valid`=1 and `req_addr`=pc. On `req_ready`, go to WAIT. `req_addr` stays stable until accepted.
- **WAIT:** the response is implicitly ready.
  - On `resp_valid` with `resp_err`=0: latch `inst`=`resp_data` and `inst_pc`=pc, go to DISP.
  - On `resp_valid` with `resp_err`=1: go to FAULT.
- **DISP:** `inst_valid`=1. `inst` and `inst_pc` are held. On `inst_ready`, go to EXEC.
- **EXEC:** on `commit_valid`, compute next PC and go to REQ.
  - next PC = (`PCBctr` ? `rs1` : pc) + (`PCActr` ? `imm` : 32'd4), modulo 2^32.
  - When `PCBctr`=1, clear bit 0 of the result (jalr).
  - If next PC[1:0] != 0: pc keeps its old value, go to FAULT.
  - Otherwise pc = next PC.
- **FAULT:** `fault`=1, and `req_valid` and `inst_valid` are 0 until reset.
- Ignored events:
  - `commit_valid` outside EXEC.
  - `resp_valid` outside WAIT.
  - The imem contract requires `resp_valid` no earlier than the cycle after the request is accepted.

## Timing
- Reset values:
  - `req_valid`=0, `inst_valid`=0, `fault`=0.
  - `inst`=32'h0000_0013 (nop), `inst_pc`=`RESET_PC`, pc=`RESET_PC`.
- `req_valid`, `req_addr` and `inst_valid` decode from registered state, with no combinational path from inputs.
- First request: `req_valid` rises on the 2nd rising edge after `rst_n` deasserts.
- Best-case loop (ready/valid same cycle, commit the cycle after accept): 4 cycles per instruction.
  - REQ 1, WAIT ≥1, DISP ≥1, EXEC ≥1.
- Commit at edge t: `req_addr` = new PC and `req_valid`=1 in cycle t+1.
- Wrap-around: pc 32'hFFFF_FFFC + 4 = 32'h0, which is legal.
- Reset mid-transaction: return to BOOT immediately. An outstanding imem response is dropped because WAIT is exited.

## Structure
- Shared package `ysyx_24100027_pkg`:
  - state enum (BOOT, REQ, WAIT, DISP, EXEC, FAULT);
  - `RESET_PC` default;
  - `NOP_INST` = 32'h0000_0013.
- Sub-module `ysyx_24100027_nextpc`: combinational base/addend mux, 32-bit add, jalr bit-0 clear, misalignment flag. The FSM and registers stay in the IFU.

## Test plan
- **Reset then fetch:** release `rst_n`, `req_ready`=1, resp 1 cycle later with 32'h00000013.
  - `req_addr`=32'h8000_0000 on the 2nd edge.
  - `inst`=32'h13 and `inst_pc`=32'h8000_0000 with `inst_valid`=1.
- **Sequential commit:** `PCActr`=0, `PCBctr`=0 → next `req_addr`=32'h8000_0004.
- **Branch/jal:** `PCActr`=1, `PCBctr`=0, `imm`=32'hFFFF_FFF8 at pc 32'h8000_0010 → `req_addr`=32'h8000_0008.
- **jalr:** `PCActr`=1, `PCBctr`=1, `rs1`=32'h8000_1001, `imm`=4 → `req_addr`=32'h8000_1004.
  - Variant `imm`=1 → 32'h8000_1002 is misaligned → `fault`=1 and `req_valid` stays 0.
- **Backpressure:** `req_ready` low for 3 cycles, then `inst_ready` low for 2 cycles.
  - `req_addr` stable while waiting; `inst`/`inst_pc` held; stray `commit_valid` in DISP ignored; exactly one fetch per commit.
- **Bus error and mid-flight reset:** `resp_err`=1 → `fault`=1.
  - Assert `rst_n`=0 while in WAIT → all outputs at reset values that cycle; refetch from `RESET_PC` after release.
